// File: rtl/ex_pkg.sv
// ---------------------------------------------------------------------------
// ex_pkg -- shared definitions for the execute stage.
//   kind_e      : instruction kind carried from decode (ALU/BRANCH/JAL/JALR)
//   alu_op_e    : 4-bit ALU operation encoding shared with decode
//   s1_t        : operand-stage register contents
//   sel_operand : forwarding mux for one source operand
//   clear_lsb   : forces bit 0 of a jump target to zero
// ---------------------------------------------------------------------------
package ex_pkg;

    typedef enum logic [1:0] {
        KIND_ALU    = 2'b00,
        KIND_BRANCH = 2'b01,
        KIND_JAL    = 2'b10,
        KIND_JALR   = 2'b11
    } kind_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_BEQ  = 4'b1001,
        ALU_BNE  = 4'b1010,
        ALU_BLT  = 4'b1011,
        ALU_BGE  = 4'b1100,
        ALU_SRA  = 4'b1101,
        ALU_BLTU = 4'b1110,
        ALU_BGEU = 4'b1111
    } alu_op_e;

    // Return address offset for JAL/JALR.
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        alu_op_e     alu_op;
        logic        src1_pc;
        logic        src2_imm;
        kind_e       kind;
        logic [4:0]  rd;
        logic        rd_we;
    } s1_t;

    // Picks the freshest value for one source register. The younger
    // instruction sitting in S1 wins over the older one in S2; x0 never
    // forwards.
    function automatic logic [31:0] sel_operand(
        input logic [4:0]  idx,
        input logic [31:0] rf_val,
        input logic        s1_we,
        input logic [4:0]  s1_rd,
        input logic [31:0] s1_val,
        input logic        s2_we,
        input logic [4:0]  s2_rd,
        input logic [31:0] s2_val
    );
        logic [31:0] res;
        if ((idx != 5'd0) && s1_we && (s1_rd == idx)) begin
            res = s1_val;
        end else if ((idx != 5'd0) && s2_we && (s2_rd == idx)) begin
            res = s2_val;
        end else begin
            res = rf_val;
        end
        return res;
    endfunction

    // Jump targets are halfword-aligned by clearing bit 0 only; bit 1 is
    // left alone and no misalignment trap is raised here.
    function automatic logic [31:0] clear_lsb(input logic [31:0] v);
        return v & ~32'd1;
    endfunction

endpackage

// File: rtl/alu_32_bit.sv
// ---------------------------------------------------------------------------
// alu_32_bit -- combinational 32-bit integer ALU.
//   a, b : operands
//   op   : operation (ex_pkg::alu_op_e)
//   y    : result; compare ops return 0/1 in bit 0
// Arithmetic wraps modulo 2^32; shifts use b[4:0].
// ---------------------------------------------------------------------------
module alu_32_bit
    import ex_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_e     op,
    output logic [31:0] y
);

    logic [4:0] shamt_s;
    logic       lt_s;
    logic       ltu_s;
    logic       eq_s;

    assign shamt_s = b[4:0];
    assign lt_s    = ($signed(a) < $signed(b));
    assign ltu_s   = (a < b);
    assign eq_s    = (a == b);

    // Operation select.
    always_comb begin
        y = 32'd0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_SLL:  y = a << shamt_s;
            ALU_SLT:  y = {31'd0, lt_s};
            ALU_SLTU: y = {31'd0, ltu_s};
            ALU_XOR:  y = a ^ b;
            ALU_SRL:  y = a >> shamt_s;
            ALU_SRA:  y = $unsigned($signed(a) >>> shamt_s);
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            ALU_BEQ:  y = {31'd0, eq_s};
            ALU_BNE:  y = {31'd0, ~eq_s};
            ALU_BLT:  y = {31'd0, lt_s};
            ALU_BGE:  y = {31'd0, ~lt_s};
            ALU_BLTU: y = {31'd0, ltu_s};
            ALU_BGEU: y = {31'd0, ~ltu_s};
            default:  y = 32'd0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage -- two-register execute stage (S1 operands, S2 result).
//   clk, rst_n            : clock, async active-low reset
//   id_valid / id_ready   : decode handshake
//   id_pc, id_rs1/2, id_rs1/2_val, id_imm, id_alu_op, id_src1_pc,
//   id_src2_imm, id_kind, id_rd, id_rd_we : decoded instruction
//   ex_valid / ex_ready   : writeback handshake
//   ex_result, ex_rd, ex_rd_we           : writeback data
//   redirect_valid, redirect_pc          : fetch redirect (combinational,
//                                          asserted as a taken control
//                                          transfer leaves S1)
// BYPASS_EN=1 forwards results from S1/S2 into operands at S1 capture.
// ---------------------------------------------------------------------------
module ex_stage
    import ex_pkg::*;
#(
    parameter int BYPASS_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    output logic        id_ready,
    input  logic [31:0] id_pc,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [31:0] id_rs1_val,
    input  logic [31:0] id_rs2_val,
    input  logic [31:0] id_imm,
    input  logic [3:0]  id_alu_op,
    input  logic        id_src1_pc,
    input  logic        id_src2_imm,
    input  logic [1:0]  id_kind,
    input  logic [4:0]  id_rd,
    input  logic        id_rd_we,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [31:0] ex_result,
    output logic [4:0]  ex_rd,
    output logic        ex_rd_we,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    s1_t         s1_r;
    s1_t         s1_next_s;
    logic        s1_valid_r;
    logic        ex_valid_r;
    logic [31:0] ex_result_r;
    logic [4:0]  ex_rd_r;
    logic        ex_rd_we_r;

    logic        s1_adv_s;
    logic        accept_s;
    logic        redirect_s;
    logic        taken_s;
    logic [31:0] target_s;
    logic [31:0] s1_result_s;
    logic        s1_wb_we_s;
    logic [31:0] alu_a_s;
    logic [31:0] alu_b_s;
    alu_op_e     alu_op_s;
    logic [31:0] alu_y_s;
    logic [31:0] pc_imm_s;
    logic [31:0] pc_step_s;
    logic [31:0] rs1_fwd_s;
    logic [31:0] rs2_fwd_s;

    // Handshake: S1 moves on when S2 is empty or draining; a redirect cycle
    // blocks decode so the younger (wrong-path) instruction is not taken.
    assign s1_adv_s   = s1_valid_r && (!ex_valid_r || ex_ready);
    assign redirect_s = s1_valid_r && s1_adv_s && taken_s;
    assign id_ready   = (!s1_valid_r || s1_adv_s) && !redirect_s;
    assign accept_s   = id_valid && id_ready;

    // ALU operand select; JALR always computes rs1 + imm regardless of the
    // decoded operand controls.
    always_comb begin
        if (s1_r.kind == KIND_JALR) begin
            alu_a_s  = s1_r.rs1;
            alu_b_s  = s1_r.imm;
            alu_op_s = ALU_ADD;
        end else begin
            alu_a_s  = s1_r.src1_pc  ? s1_r.pc  : s1_r.rs1;
            alu_b_s  = s1_r.src2_imm ? s1_r.imm : s1_r.rs2;
            alu_op_s = s1_r.alu_op;
        end
    end

    alu_32_bit u_alu (
        .a  (alu_a_s),
        .b  (alu_b_s),
        .op (alu_op_s),
        .y  (alu_y_s)
    );

    assign pc_imm_s  = s1_r.pc + s1_r.imm;
    assign pc_step_s = s1_r.pc + PC_STEP;

    // Per-kind result, write enable, taken flag and target.
    always_comb begin
        taken_s     = 1'b0;
        target_s    = pc_imm_s;
        s1_result_s = alu_y_s;
        s1_wb_we_s  = s1_r.rd_we;
        case (s1_r.kind)
            KIND_ALU: begin
                taken_s = 1'b0;
            end
            KIND_BRANCH: begin
                taken_s    = alu_y_s[0];
                s1_wb_we_s = 1'b0;
            end
            KIND_JAL: begin
                taken_s     = 1'b1;
                s1_result_s = pc_step_s;
            end
            KIND_JALR: begin
                taken_s     = 1'b1;
                target_s    = clear_lsb(alu_y_s);
                s1_result_s = pc_step_s;
            end
            default: begin
                taken_s = 1'b0;
            end
        endcase
    end

    assign redirect_valid = redirect_s;
    assign redirect_pc    = redirect_s ? target_s : 32'd0;

    // Operand forwarding at S1 capture.
    always_comb begin
        if (BYPASS_EN != 0) begin
            rs1_fwd_s = sel_operand(id_rs1, id_rs1_val,
                                    s1_valid_r && s1_wb_we_s, s1_r.rd, s1_result_s,
                                    ex_valid_r && ex_rd_we_r, ex_rd_r, ex_result_r);
            rs2_fwd_s = sel_operand(id_rs2, id_rs2_val,
                                    s1_valid_r && s1_wb_we_s, s1_r.rd, s1_result_s,
                                    ex_valid_r && ex_rd_we_r, ex_rd_r, ex_result_r);
        end else begin
            rs1_fwd_s = id_rs1_val;
            rs2_fwd_s = id_rs2_val;
        end
    end

    // Next S1 contents from decode.
    always_comb begin
        s1_next_s          = '0;
        s1_next_s.pc       = id_pc;
        s1_next_s.rs1      = rs1_fwd_s;
        s1_next_s.rs2      = rs2_fwd_s;
        s1_next_s.imm      = id_imm;
        s1_next_s.alu_op   = alu_op_e'(id_alu_op);
        s1_next_s.src1_pc  = id_src1_pc;
        s1_next_s.src2_imm = id_src2_imm;
        s1_next_s.kind     = kind_e'(id_kind);
        s1_next_s.rd       = id_rd;
        s1_next_s.rd_we    = id_rd_we;
    end

    // S1 operand register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_r       <= '0;
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_r       <= s1_next_s;
        end else if (s1_adv_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // S2 result register; refill takes priority over drain so a full
    // pipeline streams with no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_r  <= 1'b0;
            ex_result_r <= 32'd0;
            ex_rd_r     <= 5'd0;
            ex_rd_we_r  <= 1'b0;
        end else if (s1_adv_s) begin
            ex_valid_r  <= 1'b1;
            ex_result_r <= s1_result_s;
            ex_rd_r     <= s1_r.rd;
            ex_rd_we_r  <= s1_wb_we_s;
        end else if (ex_ready) begin
            ex_valid_r  <= 1'b0;
        end
    end

    assign ex_valid  = ex_valid_r;
    assign ex_result = ex_result_r;
    assign ex_rd     = ex_rd_r;
    assign ex_rd_we  = ex_rd_we_r;

endmodule

// File: tb/tb_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_stage -- directed, table-driven bench for ex_stage. A second
// instance with forwarding disabled shares the same stimulus.
// ---------------------------------------------------------------------------
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [31:0] id_rs1_val;
    logic [31:0] id_rs2_val;
    logic [31:0] id_imm;
    logic [3:0]  id_alu_op;
    logic        id_src1_pc;
    logic        id_src2_imm;
    logic [1:0]  id_kind;
    logic [4:0]  id_rd;
    logic        id_rd_we;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_result;
    logic [4:0]  ex_rd;
    logic        ex_rd_we;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        nb_id_ready;
    logic        nb_ex_valid;
    logic [31:0] nb_ex_result;
    logic [4:0]  nb_ex_rd;
    logic        nb_ex_rd_we;
    logic        nb_redirect_valid;
    logic [31:0] nb_redirect_pc;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ex_stage #(.BYPASS_EN(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
        .id_alu_op(id_alu_op), .id_src1_pc(id_src1_pc), .id_src2_imm(id_src2_imm),
        .id_kind(id_kind), .id_rd(id_rd), .id_rd_we(id_rd_we),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_result(ex_result), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    ex_stage #(.BYPASS_EN(0)) u_dut_nb (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ready(nb_id_ready),
        .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
        .id_alu_op(id_alu_op), .id_src1_pc(id_src1_pc), .id_src2_imm(id_src2_imm),
        .id_kind(id_kind), .id_rd(id_rd), .id_rd_we(id_rd_we),
        .ex_valid(nb_ex_valid), .ex_ready(ex_ready),
        .ex_result(nb_ex_result), .ex_rd(nb_ex_rd), .ex_rd_we(nb_ex_rd_we),
        .redirect_valid(nb_redirect_valid), .redirect_pc(nb_redirect_pc)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] r1v;
        logic [31:0] r2v;
        logic [31:0] imm;
        logic [3:0]  op;
        logic        s1pc;
        logic        s2imm;
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] exp_res;
        logic        exp_we;
        logic        exp_redir;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(
        input logic [31:0] pc, input logic [31:0] r1v, input logic [31:0] r2v,
        input logic [31:0] imm, input logic [3:0] op, input logic s1pc,
        input logic s2imm, input logic [1:0] kind, input logic [4:0] rd,
        input logic we, input logic [31:0] exp_res, input logic exp_we,
        input logic exp_redir, input logic [31:0] exp_pc);
        vec_t v;
        v.pc = pc; v.r1v = r1v; v.r2v = r2v; v.imm = imm; v.op = op;
        v.s1pc = s1pc; v.s2imm = s2imm; v.kind = kind; v.rd = rd; v.we = we;
        v.exp_res = exp_res; v.exp_we = exp_we; v.exp_redir = exp_redir;
        v.exp_pc = exp_pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(
        input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
        input logic [31:0] r1v, input logic [31:0] r2v, input logic [31:0] imm,
        input logic [3:0] op, input logic s1pc, input logic s2imm,
        input logic [1:0] kind, input logic [4:0] rd, input logic we);
        id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rs1_val = r1v; id_rs2_val = r2v;
        id_imm = imm; id_alu_op = op; id_src1_pc = s1pc; id_src2_imm = s2imm;
        id_kind = kind; id_rd = rd; id_rd_we = we;
    endtask

    logic       acc;
    int         idx;
    int         nout;
    logic [31:0] stall_imm [3];
    logic [4:0]  stall_rd  [3];

    initial begin
        // kind: 0 ALU, 1 BRANCH, 2 JAL, 3 JALR
        vecs[0]  = mk(32'h0, 32'd5, 32'd0, 32'd7, 4'h0, 1'b0, 1'b1, 2'd0, 5'd3, 1'b1, 32'd12, 1'b1, 1'b0, 32'h0);
        vecs[1]  = mk(32'h0, 32'd3, 32'd5, 32'd0, 4'h8, 1'b0, 1'b0, 2'd0, 5'd5, 1'b1, 32'hFFFFFFFE, 1'b1, 1'b0, 32'h0);
        vecs[2]  = mk(32'h0, 32'd1, 32'h23, 32'd0, 4'h1, 1'b0, 1'b0, 2'd0, 5'd5, 1'b1, 32'd8, 1'b1, 1'b0, 32'h0);
        vecs[3]  = mk(32'h0, 32'hFFFFFFFF, 32'd1, 32'd0, 4'h2, 1'b0, 1'b0, 2'd0, 5'd5, 1'b1, 32'd1, 1'b1, 1'b0, 32'h0);
        vecs[4]  = mk(32'h0, 32'hFFFFFFFF, 32'd1, 32'd0, 4'h3, 1'b0, 1'b0, 2'd0, 5'd5, 1'b1, 32'd0, 1'b1, 1'b0, 32'h0);
        vecs[5]  = mk(32'h0, 32'h80000000, 32'd4, 32'd0, 4'hD, 1'b0, 1'b0, 2'd0, 5'd5, 1'b1, 32'hF8000000, 1'b1, 1'b0, 32'h0);
        vecs[6]  = mk(32'h0, 32'h80000000, 32'd4, 32'd0, 4'h5, 1'b0, 1'b0, 2'd0, 5'd5, 1'b1, 32'h08000000, 1'b1, 1'b0, 32'h0);
        vecs[7]  = mk(32'h0, 32'hFF00FF00, 32'h0FF00FF0, 32'd0, 4'h4, 1'b0, 1'b0, 2'd0, 5'd6, 1'b1, 32'hF0F0F0F0, 1'b1, 1'b0, 32'h0);
        vecs[8]  = mk(32'h0, 32'hFF00FF00, 32'h0FF00FF0, 32'd0, 4'h6, 1'b0, 1'b0, 2'd0, 5'd6, 1'b1, 32'hFFF0FFF0, 1'b1, 1'b0, 32'h0);
        vecs[9]  = mk(32'h0, 32'hFF00FF00, 32'h0FF00FF0, 32'd0, 4'h7, 1'b0, 1'b0, 2'd0, 5'd6, 1'b1, 32'h0F000F00, 1'b1, 1'b0, 32'h0);
        vecs[10] = mk(32'h0, 32'hFFFFFFFF, 32'd2, 32'd0, 4'h0, 1'b0, 1'b0, 2'd0, 5'd7, 1'b1, 32'd1, 1'b1, 1'b0, 32'h0);
        vecs[11] = mk(32'h1000, 32'd0, 32'd0, 32'h10, 4'h0, 1'b1, 1'b1, 2'd0, 5'd8, 1'b1, 32'h1010, 1'b1, 1'b0, 32'h0);
        vecs[12] = mk(32'h100, 32'd7, 32'd7, 32'h20, 4'h9, 1'b0, 1'b0, 2'd1, 5'd5, 1'b1, 32'h0, 1'b0, 1'b1, 32'h120);
        vecs[13] = mk(32'h100, 32'd7, 32'd7, 32'h20, 4'hA, 1'b0, 1'b0, 2'd1, 5'd5, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        vecs[14] = mk(32'h40, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFF0, 4'hB, 1'b0, 1'b0, 2'd1, 5'd0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h30);
        vecs[15] = mk(32'h40, 32'd1, 32'hFFFFFFFF, 32'h8, 4'hF, 1'b0, 1'b0, 2'd1, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        vecs[16] = mk(32'h80, 32'd5, 32'd5, 32'h8, 4'hC, 1'b0, 1'b0, 2'd1, 5'd0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h88);
        vecs[17] = mk(32'h80, 32'd1, 32'd2, 32'hFFFFFF80, 4'hE, 1'b0, 1'b0, 2'd1, 5'd0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        vecs[18] = mk(32'h300, 32'd0, 32'd0, 32'h100, 4'h0, 1'b0, 1'b0, 2'd2, 5'd1, 1'b1, 32'h304, 1'b1, 1'b1, 32'h400);
        vecs[19] = mk(32'h200, 32'h1003, 32'd0, 32'd4, 4'h0, 1'b0, 1'b1, 2'd3, 5'd1, 1'b1, 32'h204, 1'b1, 1'b1, 32'h1006);
        vecs[20] = mk(32'hFFFFFFF0, 32'd0, 32'd0, 32'h20, 4'h0, 1'b0, 1'b0, 2'd2, 5'd2, 1'b1, 32'hFFFFFFF4, 1'b1, 1'b1, 32'h10);

        // Reset state
        rst_n = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
        drive(32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0);
        #1;
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_ex_result", ex_result, 32'd0);
        chk("rst_ex_rd", {27'd0, ex_rd}, 32'd0);
        chk("rst_ex_rd_we", {31'd0, ex_rd_we}, 32'd0);
        chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_id_ready", {31'd0, id_ready}, 32'd1);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Table: one instruction at a time, no source dependencies
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            drive(vecs[i].pc, 5'd0, 5'd0, vecs[i].r1v, vecs[i].r2v, vecs[i].imm, vecs[i].op,
                  vecs[i].s1pc, vecs[i].s2imm, vecs[i].kind, vecs[i].rd, vecs[i].we);
            id_valid = 1'b1;
            @(posedge clk); #1;
            id_valid = 1'b0;
            chk($sformatf("v%0d_redirect_valid", i), {31'd0, redirect_valid}, {31'd0, vecs[i].exp_redir});
            chk($sformatf("v%0d_id_ready", i), {31'd0, id_ready}, {31'd0, ~vecs[i].exp_redir});
            if (vecs[i].exp_redir)
                chk($sformatf("v%0d_redirect_pc", i), redirect_pc, vecs[i].exp_pc);
            @(posedge clk); #1;
            chk($sformatf("v%0d_ex_valid", i), {31'd0, ex_valid}, 32'd1);
            chk($sformatf("v%0d_ex_rd_we", i), {31'd0, ex_rd_we}, {31'd0, vecs[i].exp_we});
            chk($sformatf("v%0d_ex_rd", i), {27'd0, ex_rd}, {27'd0, vecs[i].rd});
            if (vecs[i].kind != 2'd1)
                chk($sformatf("v%0d_ex_result", i), ex_result, vecs[i].exp_res);
            chk($sformatf("v%0d_redirect_after", i), {31'd0, redirect_valid}, 32'd0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_drained", i), {31'd0, ex_valid}, 32'd0);
        end

        // Back-to-back dependencies: S1 and S2 forwarding, no bubbles
        @(negedge clk);
        drive(32'h0, 5'd1, 5'd2, 32'd10, 32'd20, 32'd0, 4'h0, 1'b0, 1'b0, 2'd0, 5'd3, 1'b1);
        id_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drive(32'h4, 5'd3, 5'd0, 32'd0, 32'd0, 32'd1, 4'h8, 1'b0, 1'b1, 2'd0, 5'd4, 1'b1);
        @(posedge clk); #1;
        chk("dep1_ex_result", ex_result, 32'd30);
        chk("dep1_ex_rd", {27'd0, ex_rd}, 32'd3);
        chk("dep1_nb_ex_result", nb_ex_result, 32'd30);
        @(negedge clk);
        drive(32'h8, 5'd3, 5'd4, 32'd0, 32'd0, 32'd0, 4'h0, 1'b0, 1'b0, 2'd0, 5'd5, 1'b1);
        @(posedge clk); #1;
        id_valid = 1'b0;
        chk("dep2_ex_valid", {31'd0, ex_valid}, 32'd1);
        chk("dep2_ex_result_s1_bypass", ex_result, 32'd29);
        chk("dep2_nb_ex_result", nb_ex_result, 32'hFFFFFFFF);
        chk("dep2_nb_ex_rd", {27'd0, nb_ex_rd}, 32'd4);
        @(posedge clk); #1;
        chk("dep3_ex_result_s1s2_bypass", ex_result, 32'd59);
        chk("dep3_ex_rd", {27'd0, ex_rd}, 32'd5);
        chk("dep3_nb_ex_result", nb_ex_result, 32'd0);
        chk("dep3_nb_ex_rd_we", {31'd0, nb_ex_rd_we}, 32'd1);
        @(posedge clk); #1;
        chk("dep_drained", {31'd0, ex_valid}, 32'd0);
        chk("dep_nb_drained", {31'd0, nb_ex_valid}, 32'd0);

        // Taken branch: younger instruction offered in the redirect cycle
        @(negedge clk);
        drive(32'h100, 5'd0, 5'd0, 32'd7, 32'd7, 32'h20, 4'h9, 1'b0, 1'b0, 2'd1, 5'd0, 1'b0);
        id_valid = 1'b1;
        @(posedge clk); #1;
        chk("br_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        chk("br_redirect_pc", redirect_pc, 32'h120);
        chk("br_id_ready", {31'd0, id_ready}, 32'd0);
        chk("br_nb_redirect_valid", {31'd0, nb_redirect_valid}, 32'd1);
        drive(32'h104, 5'd0, 5'd0, 32'd0, 32'd0, 32'd55, 4'h0, 1'b0, 1'b1, 2'd0, 5'd9, 1'b1);
        @(posedge clk); #1;
        id_valid = 1'b0;
        chk("br_ex_valid", {31'd0, ex_valid}, 32'd1);
        chk("br_ex_rd_we", {31'd0, ex_rd_we}, 32'd0);
        chk("br_redirect_once", {31'd0, redirect_valid}, 32'd0);
        @(posedge clk); #1;
        chk("br_younger_dropped", {31'd0, ex_valid}, 32'd0);

        // Downstream stall with three instructions offered
        stall_imm[0] = 32'd100; stall_imm[1] = 32'd200; stall_imm[2] = 32'd300;
        stall_rd[0] = 5'd5; stall_rd[1] = 5'd6; stall_rd[2] = 5'd7;
        idx = 0; nout = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            ex_ready = (cyc >= 5);
            if (idx < 3) begin
                drive(32'h0, 5'd0, 5'd0, 32'd0, 32'd0, stall_imm[idx], 4'h0, 1'b0, 1'b1, 2'd0, stall_rd[idx], 1'b1);
                id_valid = 1'b1;
            end else begin
                id_valid = 1'b0;
            end
            #1;
            if (cyc >= 2 && cyc <= 4) begin
                chk($sformatf("stall%0d_ex_valid", cyc), {31'd0, ex_valid}, 32'd1);
                chk($sformatf("stall%0d_ex_result", cyc), ex_result, 32'd100);
                chk($sformatf("stall%0d_id_ready", cyc), {31'd0, id_ready}, 32'd0);
            end
            acc = id_valid && id_ready;
            if (ex_valid && ex_ready) begin
                if (nout < 3) begin
                    chk($sformatf("stall_out%0d_result", nout), ex_result, stall_imm[nout]);
                    chk($sformatf("stall_out%0d_rd", nout), {27'd0, ex_rd}, {27'd0, stall_rd[nout]});
                end
                nout++;
            end
            @(posedge clk);
            if (acc) idx++;
        end
        chk("stall_out_count", nout, 32'd3);
        ex_ready = 1'b1;

        // Reset mid-stream with ex_valid and redirect asserted
        @(negedge clk);
        drive(32'h4FC, 5'd0, 5'd0, 32'd0, 32'd0, 32'd1, 4'h0, 1'b0, 1'b1, 2'd0, 5'd5, 1'b1);
        id_valid = 1'b1;
        @(posedge clk); #1;
        drive(32'h500, 5'd0, 5'd0, 32'd0, 32'd0, 32'h40, 4'h0, 1'b0, 1'b0, 2'd2, 5'd1, 1'b1);
        @(posedge clk); #1;
        id_valid = 1'b0;
        chk("mid_ex_valid", {31'd0, ex_valid}, 32'd1);
        chk("mid_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("arst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("arst_redirect_pc", redirect_pc, 32'd0);
        chk("arst_ex_result", ex_result, 32'd0);
        chk("arst_ex_rd_we", {31'd0, ex_rd_we}, 32'd0);
        chk("arst_id_ready", {31'd0, id_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("post_rst_redirect", {31'd0, redirect_valid}, 32'd0);
        chk("post_rst_id_ready", {31'd0, id_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameter BYPASS_EN, default 1: 1 enables operand forwarding (REQ-033); 0 uses id_rs*_val unmodified.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 id_valid  input  1  decode offers an instruction.
REQ-005 id_ready  output  1  stage accepts; transfer on id_valid && id_ready.
REQ-006 id_pc  input  32  instruction PC.
REQ-007 id_rs1, id_rs2  input  5 each  source register indices.
REQ-008 id_rs1_val, id_rs2_val  input  32 each  register-file read data.
REQ-009 id_imm  input  32  sign-extended immediate.
REQ-010 id_alu_op  input  4  ALU operation code, shared package encoding.
REQ-011 id_src1_pc  input  1  operand A = PC instead of rs1.
REQ-012 id_src2_imm  input  1  operand B = imm instead of rs2.
REQ-013 id_kind  input  2  00 ALU, 01 BRANCH, 10 JAL, 11 JALR.
REQ-014 id_rd  input  5;  id_rd_we  input  1  destination index and write enable.
REQ-015 ex_valid  output  1  result register holds an instruction.
REQ-016 ex_ready  input  1  downstream accepts; transfer on ex_valid && ex_ready.
REQ-017 ex_result  output  32;  ex_rd  output  5;  ex_rd_we  output  1  writeback data.
REQ-018 redirect_valid  output  1;  redirect_pc  output  32  fetch redirect.

Function
REQ-019 Two registered stages: S1 (operands), S2 (result); throughput one instruction per cycle.
REQ-020 s1_adv = s1_valid && (!ex_valid || ex_ready); S1 content moves to S2 on s1_adv.
REQ-021 id_ready = (!s1_valid || s1_adv) && !redirect_valid.
REQ-022 Accept at edge N -> ex_valid high after edge N+1 without stall.
REQ-023 ALU inputs from S1: A = src1_pc ? pc : rs1; B = src2_imm ? imm : rs2; op = alu_op.
REQ-024 Kind ALU: ex_result = ALU output; no redirect.
REQ-025 Kind BRANCH: taken = ALU output bit 0; target = pc + imm; ex_rd_we forced 0.
REQ-026 Kind JAL: always taken, target = pc + imm; ex_result = pc + 4.
REQ-027 Kind JALR: ALU op ADD on rs1 + imm; target = that sum with bit 0 cleared; ex_result = pc + 4.
REQ-028 redirect_valid = s1_valid && s1_adv && taken; combinational, one cycle per instruction; redirect_pc = target.
REQ-029 Redirect cycle: no acceptance from decode (younger instruction dropped by upstream flush).
REQ-030 Target bit 1 set: passed through unchanged; no trap generated.
REQ-031 ex_ready low: S2 outputs held stable; S1 holds; id_ready low once S1 full.
REQ-032 S2 drain and refill in same cycle permitted; no bubble inserted.
REQ-033 Bypass at S1 capture, per source, index != 0: S1 valid, rd_we, rd match -> S1 writeback value; else S2 valid, ex_rd_we, ex_rd match -> ex_result; else id_rs*_val.
REQ-034 Adders wrap modulo 2^32; no overflow flag.

Reset
REQ-035 rst_n low: s1_valid, ex_valid cleared immediately; all data registers to 0.
REQ-036 Outputs during/after reset: ex_valid 0, ex_result 0, ex_rd 0, ex_rd_we 0, redirect_valid 0, redirect_pc 0, id_ready 1.
REQ-037 Reset mid-operation discards in-flight instructions; no redirect emitted.

Structure
REQ-038 Shared package ex_pkg: id_kind encoding, 4-bit ALU op constants (ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111, BEQ 1001, BNE 1010, BLT 1011, BGE 1100, BLTU 1110, BGEU 1111).
REQ-039 One sub-module: the team's alu_32_bit, instantiated once on S1; PC adders local.

Verification
REQ-040 ADDI: rs1_val=5, imm=7, op 0000, src2_imm=1, rd=3 -> ex_result=12, ex_rd=3, ex_rd_we=1 two edges later.
REQ-041 Dependency: x3=10+20 then x4=x3-1 with stale id_rs1_val=0 -> second ex_result=29 (S1 bypass); BYPASS_EN=0 -> 0xFFFFFFFF.
REQ-042 BEQ pc=0x100, rs1=rs2=7, imm=0x20 -> redirect_valid one cycle, redirect_pc=0x120, id_ready 0 that cycle, ex_rd_we 0.
REQ-043 JALR pc=0x200, rs1=0x1003, imm=4, rd=1 -> ex_result=0x204, redirect_pc=0x1006.
REQ-044 ex_ready low 3 cycles, three instructions offered -> ex_result stable, id_ready low after S1 fills; on release all three exit in order, no loss or duplicate.
REQ-045 rst_n low mid-stream with ex_valid=1 -> ex_valid and redirect_valid 0 without clock edge; id_ready 1 afterwards.
